dff_latch_bist: RTL and testbench
=================================

Name: dff_latch_bist

Overview:
- On-chip built-in self-test engine for one D flip-flop and one D latch storage pair.
- Drives the pair's d/en pins from an LFSR stimulus source and samples the q / q_bar outputs every cycle.
- Compares those outputs against internal golden models and reports a pass/fail result, an error count and the index of the first failing vector.
- Sits beside the storage-element under test and replaces the simulation-only bench with a synthesizable checker.

Parameters:
- SEED, 16'hACE1, LFSR seed. A value of 0 is replaced by 16'h0001.
- ERR_W, 8, width of the error counter. The counter saturates at all-ones.
- EN_FORCE, 0, when 1 en_out is held at 1 during RUN (pure-transparency test); when 0 en_out comes from the LFSR.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- num_vectors  in  16  number of vectors to apply; latched on accepted start.
- d_out  out  1  registered d drive to the unit under test.
- en_out  out  1  registered latch-enable drive to the unit under test.
- q_ff_in  in  1  flip-flop q (flip-flop clocked by clk).
- q_bar_ff_in  in  1  flip-flop q_bar.
- q_latch_in  in  1  latch q.
- q_bar_latch_in  in  1  latch q_bar.
- busy  out  1  high in PRIME, RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid in DONE: 1 when err_count == 0.
- err_count  out  ERR_W  total mismatching check cycles, saturating.
- first_err_idx  out  16  vector index at the first mismatch; 16'hFFFF if no mismatch.

Behaviour:
- Reset values:
  - state=IDLE, d_out=0, en_out=0, busy=0, done=0, pass=0.
  - err_count=0, first_err_idx=16'hFFFF, lfsr=SEED.
  - Model valid flags ff_v and lat_v cleared.
- Reset is honoured in every state. A reset mid-run aborts the run with no done pulse and restores all reset values.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifts once per RUN cycle.
  - d_out <= lfsr[0].
  - en_out <= EN_FORCE ? 1 : lfsr[1].
- FSM:
  - IDLE: start=1 latches num_vectors and clears err_count/first_err_idx/valid flags. Goes to DONE with pass=1 if num_vectors==0, else to PRIME.
  - PRIME (1 cycle): drives vector 0 with no comparisons, then goes to RUN. Vector index idx=0.
  - RUN: each cycle drives vector idx+1 and checks the response to vector idx. When idx == num_vectors-1, goes to DRAIN.
  - DRAIN (1 cycle): checks the last vector's flip-flop capture. d_out/en_out hold their values. Goes to DONE.
  - DONE: outputs hold; pass=(err_count==0). start=1 begins a new run exactly as from IDLE.
- start while busy is ignored.
- Golden flip-flop model:
  - m_ff <= d_out at every edge in PRIME/RUN; ff_v is set at the first such edge.
  - Check when ff_v: q_ff_in == m_ff and q_bar_ff_in == ~m_ff.
- Golden latch model (latch is transparent, combinational in this domain):
  - Expected value is d_out when en_out=1, else the held m_lat.
  - m_lat <= d_out on edges where en_out=1; lat_v is set on the first such edge.
  - Check when (en_out=1 or lat_v): q_latch_in == expected and q_bar_latch_in == ~expected.
- Mismatch accounting:
  - Any failing check in a cycle increments err_count by exactly 1, saturating at 2^ERR_W-1.
  - The first mismatch loads first_err_idx with the idx being checked.
- Latency: a run takes num_vectors+2 cycles from start to done (PRIME + num_vectors RUN cycles + DRAIN). done is visible the cycle after DRAIN.

Test Plan:
- Healthy DFF and latch models, num_vectors=100, SEED default -> done after 102 cycles from start, pass=1, err_count=0, first_err_idx=16'hFFFF.
- q_ff_in stuck-at-0, num_vectors=32 -> pass=0, err_count equals the number of cycles where m_ff=1 (checked against the bench model), first_err_idx = first vector with d=1.
- q_bar_latch_in tied to q_latch_in (not inverted), EN_FORCE=1 -> every checked cycle fails: err_count=num_vectors, first_err_idx=0.
- ERR_W=4, inverted q_ff_in, num_vectors=40 -> err_count saturates at 15 and stays there.
- num_vectors=0 -> DONE the cycle after start, pass=1, d_out/en_out still 0; then start with num_vectors=5 -> a normal run completes.
- Assert rst during RUN -> next cycle state=IDLE, busy=0, done=0, err_count=0, d_out=en_out=0; start pulses during busy are ignored.

Source files
------------

// File: rtl/dff_latch_bist.sv
// dff_latch_bist: built-in self-test engine for one D flip-flop and one
// transparent D latch. An LFSR supplies d/en stimulus, the q/q_bar returns
// are compared every cycle against golden models, and the engine reports
// pass/fail, a saturating error count and the first failing vector index.
//
// Run timeline for N = num_vectors (N > 0):
//   start edge : vector 0 is put on d_out/en_out, LFSR reloaded with seed
//   PRIME      : vector 0 settles into the unit, nothing is checked
//   RUN idx    : responses are checked, vector idx+1 is driven at the edge
//   DRAIN      : only the flip-flop capture of the last vector is checked
//   DONE       : results held until the next start
module dff_latch_bist #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          ERR_W    = 8,
    parameter bit          EN_FORCE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_vectors,
    output logic             d_out,
    output logic             en_out,
    input  logic             q_ff_in,
    input  logic             q_bar_ff_in,
    input  logic             q_latch_in,
    input  logic             q_bar_latch_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      first_err_idx
);

    // FSM encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRIME = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [15:0]      NO_ERR  = 16'hFFFF;

    logic [2:0]  state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic        lfsr_fb;
    logic [15:0] num_lat;
    logic [15:0] idx;
    logic        last_vec;
    logic        start_ok;

    logic        m_ff;
    logic        ff_v;
    logic        m_lat;
    logic        lat_v;

    logic        lat_exp;
    logic        ff_fail;
    logic        lat_fail;
    logic        check_fail;

    // Fibonacci LFSR step (taps 16,14,13,11), shifting toward bit 0
    always_comb begin
        lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
        lfsr_nxt = {lfsr_fb, lfsr[15:1]};
    end

    // Run control decode: accepted start and last-vector detection
    always_comb begin
        start_ok = start && ((state == S_IDLE) || (state == S_DONE));
        last_vec = (idx == (num_lat - 16'd1));
    end

    // Golden comparison: flip-flop always, latch only in RUN, none in PRIME
    always_comb begin
        lat_exp  = en_out ? d_out : m_lat;
        ff_fail  = ff_v && ((q_ff_in != m_ff) || (q_bar_ff_in != ~m_ff));
        lat_fail = (en_out || lat_v) &&
                   ((q_latch_in != lat_exp) || (q_bar_latch_in != ~lat_exp));
        check_fail = 1'b0;
        if (state == S_RUN) begin
            check_fail = ff_fail || lat_fail;
        end else if (state == S_DRAIN) begin
            check_fail = ff_fail;
        end
    end

    // Sequencer: IDLE -> PRIME -> RUN x N -> DRAIN -> DONE, vector index
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= 16'd0;
            num_lat <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        num_lat <= num_vectors;
                        idx     <= 16'd0;
                        state   <= (num_vectors == 16'd0) ? S_DONE : S_PRIME;
                    end
                end
                S_PRIME: begin
                    idx   <= 16'd0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (last_vec) begin
                        state <= S_DRAIN;
                    end else begin
                        idx <= idx + 16'd1;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stimulus drive: vector 0 on start, next LFSR vector each RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr   <= SEED_EFF;
            d_out  <= 1'b0;
            en_out <= 1'b0;
        end else if (start_ok) begin
            lfsr <= SEED_EFF;
            if (num_vectors != 16'd0) begin
                d_out  <= SEED_EFF[0];
                en_out <= EN_FORCE ? 1'b1 : SEED_EFF[1];
            end
        end else if (state == S_RUN) begin
            lfsr   <= lfsr_nxt;
            d_out  <= lfsr_nxt[0];
            en_out <= EN_FORCE ? 1'b1 : lfsr_nxt[1];
        end
    end

    // Golden models track what the flip-flop and latch have captured
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            m_ff  <= 1'b0;
            ff_v  <= 1'b0;
            m_lat <= 1'b0;
            lat_v <= 1'b0;
        end else if ((state == S_PRIME) || (state == S_RUN)) begin
            m_ff <= d_out;
            ff_v <= 1'b1;
            if (en_out) begin
                m_lat <= d_out;
                lat_v <= 1'b1;
            end
        end
    end

    // Error accounting: one count per failing cycle, saturating; first index
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_count     <= '0;
            first_err_idx <= NO_ERR;
        end else if (check_fail) begin
            if (err_count != ERR_MAX) begin
                err_count <= err_count + 1'b1;
            end
            if (err_count == '0) begin
                first_err_idx <= idx;
            end
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy = (state == S_PRIME) || (state == S_RUN) || (state == S_DRAIN);
        done = (state == S_DONE);
        pass = (state == S_DONE) && (err_count == '0);
    end

endmodule

// File: tb/tb_dff_latch_bist.sv
// Testbench for dff_latch_bist: three engines (default, forced enable,
// 4-bit error counter) each beside a behavioural flip-flop/latch pair with
// optional planted faults on the returned q/q_bar signals.
module tb_dff_latch_bist;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    // Engine A: default parameters, optional stuck-at-0 on q_ff
    logic        start_a, d_a, en_a, busy_a, done_a, pass_a, stuck_a;
    logic [15:0] num_a, first_a;
    logic [7:0]  err_a;
    logic        ff_q_a = 1'b0;
    logic        lat_hold_a = 1'b0;
    logic        lat_q_a;

    // Engine B: EN_FORCE=1, latch q_bar tied to latch q
    logic        start_b, d_b, en_b, busy_b, done_b, pass_b;
    logic [15:0] num_b, first_b;
    logic [7:0]  err_b;
    logic        ff_q_b = 1'b0;
    logic        lat_hold_b = 1'b0;
    logic        lat_q_b;

    // Engine C: ERR_W=4, flip-flop q inverted
    logic        start_c, d_c, en_c, busy_c, done_c, pass_c;
    logic [15:0] num_c, first_c;
    logic [3:0]  err_c;
    logic        ff_q_c = 1'b0;
    logic        lat_hold_c = 1'b0;
    logic        lat_q_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Units under test: real flip-flops and transparent latches
    always_ff @(posedge clk) begin
        ff_q_a <= d_a;
        ff_q_b <= d_b;
        ff_q_c <= d_c;
        if (en_a) lat_hold_a <= d_a;
        if (en_b) lat_hold_b <= d_b;
        if (en_c) lat_hold_c <= d_c;
    end
    assign lat_q_a = en_a ? d_a : lat_hold_a;
    assign lat_q_b = en_b ? d_b : lat_hold_b;
    assign lat_q_c = en_c ? d_c : lat_hold_c;

    dff_latch_bist u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .num_vectors(num_a),
        .d_out(d_a), .en_out(en_a),
        .q_ff_in(stuck_a ? 1'b0 : ff_q_a), .q_bar_ff_in(~ff_q_a),
        .q_latch_in(lat_q_a), .q_bar_latch_in(~lat_q_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_idx(first_a)
    );

    dff_latch_bist #(.EN_FORCE(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .num_vectors(num_b),
        .d_out(d_b), .en_out(en_b),
        .q_ff_in(ff_q_b), .q_bar_ff_in(~ff_q_b),
        .q_latch_in(lat_q_b), .q_bar_latch_in(lat_q_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_idx(first_b)
    );

    dff_latch_bist #(.ERR_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_c), .num_vectors(num_c),
        .d_out(d_c), .en_out(en_c),
        .q_ff_in(~ff_q_c), .q_bar_ff_in(~ff_q_c),
        .q_latch_in(lat_q_c), .q_bar_latch_in(~lat_q_c),
        .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_err_idx(first_c)
    );

    // Expected results for a stuck-at-0 q_ff run from seed ACE1: the
    // flip-flop is checked N+1 times (RUN 0..N-1 then DRAIN) and sees
    // vector 0, then vectors 0..N-1 again one cycle late.
    function automatic void model_stuck(input int n, output int err, output logic [15:0] first);
        logic [15:0] s;
        logic        d_bits [0:255];
        logic        m;
        s = 16'hACE1;
        for (int k = 0; k < n; k++) begin
            d_bits[k] = s[0];
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end
        err = 0;
        first = 16'hFFFF;
        for (int c = 0; c <= n; c++) begin
            m = (c == 0) ? d_bits[0] : d_bits[c-1];
            if (m) begin
                if (err < 255) err++;
                if (first == 16'hFFFF) first = (c < n) ? 16'(c) : 16'(n - 1);
            end
        end
    endfunction

    // Pulse start for one engine; returns at the negedge after the accepting edge
    task automatic start_run(input int which, input logic [15:0] n);
        @(negedge clk);
        case (which)
            0: begin start_a = 1'b1; num_a = n; end
            1: begin start_b = 1'b1; num_b = n; end
            default: begin start_c = 1'b1; num_c = n; end
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    // Bounded wait for done on one engine, counting clock edges
    task automatic wait_done(input int which, input int limit, inout int cycles);
        logic d;
        d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
        while (d !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
            d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy_a); end
        tests_run++; if (done_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b want 0", done_a); end
        tests_run++; if (pass_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pass: got %b want 0", pass_a); end
        tests_run++; if ({d_a, en_a} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_drive: got %b%b want 00", d_a, en_a); end
        tests_run++; if (err_a !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_err: got %0d want 0", err_a); end
        tests_run++; if (first_a !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL reset_first: got %h want ffff", first_a); end
        tests_run++; if (busy_b !== 1'b0 || en_b !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_force_idle: busy %b en %b want 0 0", busy_b, en_b); end
    endtask

    task automatic test_healthy();
        int cyc;
        cyc = 0;
        start_run(0, 16'd100);
        tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL healthy_busy: got %b want 1", busy_a); end
        wait_done(0, 300, cyc);
        tests_run++; if (cyc != 102) begin tests_failed++; $display("[TB] FAIL healthy_latency: got %0d want 102", cyc); end
        tests_run++; if (pass_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL healthy_pass: got %b want 1", pass_a); end
        tests_run++; if (err_a !== 8'd0) begin tests_failed++; $display("[TB] FAIL healthy_err: got %0d want 0", err_a); end
        tests_run++; if (first_a !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL healthy_first: got %h want ffff", first_a); end
    endtask

    task automatic test_stuck_ff();
        int cyc;
        int exp_err;
        logic [15:0] exp_first;
        model_stuck(32, exp_err, exp_first);
        stuck_a = 1'b1;
        cyc = 0;
        start_run(0, 16'd32);
        wait_done(0, 200, cyc);
        tests_run++; if (cyc != 34) begin tests_failed++; $display("[TB] FAIL stuck_latency: got %0d want 34", cyc); end
        tests_run++; if (pass_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL stuck_pass: got %b want 0", pass_a); end
        tests_run++; if (err_a !== 8'(exp_err)) begin tests_failed++; $display("[TB] FAIL stuck_err: got %0d want %0d", err_a, exp_err); end
        tests_run++; if (first_a !== exp_first) begin tests_failed++; $display("[TB] FAIL stuck_first: got %0d want %0d", first_a, exp_first); end
        stuck_a = 1'b0;
    endtask

    task automatic test_num_zero();
        int cyc;
        do_reset();
        cyc = 0;
        start_run(0, 16'd0);
        wait_done(0, 10, cyc);
        tests_run++; if (cyc != 0) begin tests_failed++; $display("[TB] FAIL zero_latency: got %0d want 0", cyc); end
        tests_run++; if (pass_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_pass: got %b want 1", pass_a); end
        tests_run++; if ({d_a, en_a} !== 2'b00) begin tests_failed++; $display("[TB] FAIL zero_drive: got %b%b want 00", d_a, en_a); end
        tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_busy: got %b want 0", busy_a); end
        cyc = 0;
        start_run(0, 16'd5);
        tests_run++; if (done_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL rerun_leaves_done: got %b want 0", done_a); end
        wait_done(0, 50, cyc);
        tests_run++; if (cyc != 7) begin tests_failed++; $display("[TB] FAIL rerun_latency: got %0d want 7", cyc); end
        tests_run++; if (pass_a !== 1'b1 || err_a !== 8'd0) begin tests_failed++; $display("[TB] FAIL rerun_result: pass %b err %0d want 1 0", pass_a, err_a); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        cyc = 0;
        start_run(0, 16'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b1;
        num_a = 16'd3;
        @(negedge clk);
        cyc++;
        start_a = 1'b0;
        wait_done(0, 100, cyc);
        tests_run++; if (cyc != 12) begin tests_failed++; $display("[TB] FAIL busy_start_latency: got %0d want 12", cyc); end
        tests_run++; if (pass_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL busy_start_pass: got %b want 1", pass_a); end
    endtask

    task automatic test_reset_midrun();
        stuck_a = 1'b1;
        start_run(0, 16'd50);
        for (int i = 0; i < 10; i++) @(negedge clk);
        tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrun_busy: got %b want 1", busy_a); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrun_state: busy %b done %b want 0 0", busy_a, done_a); end
        tests_run++; if (err_a !== 8'd0) begin tests_failed++; $display("[TB] FAIL midrun_err: got %0d want 0", err_a); end
        tests_run++; if (first_a !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL midrun_first: got %h want ffff", first_a); end
        tests_run++; if ({d_a, en_a} !== 2'b00) begin tests_failed++; $display("[TB] FAIL midrun_drive: got %b%b want 00", d_a, en_a); end
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrun_stays_idle: busy %b done %b want 0 0", busy_a, done_a); end
        stuck_a = 1'b0;
    endtask

    task automatic test_latch_tie();
        int cyc;
        cyc = 0;
        start_run(1, 16'd20);
        tests_run++; if (en_b !== 1'b1) begin tests_failed++; $display("[TB] FAIL force_en: got %b want 1", en_b); end
        wait_done(1, 100, cyc);
        tests_run++; if (cyc != 22) begin tests_failed++; $display("[TB] FAIL tie_latency: got %0d want 22", cyc); end
        tests_run++; if (err_b !== 8'd20) begin tests_failed++; $display("[TB] FAIL tie_err: got %0d want 20", err_b); end
        tests_run++; if (first_b !== 16'd0) begin tests_failed++; $display("[TB] FAIL tie_first: got %0d want 0", first_b); end
        tests_run++; if (pass_b !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie_pass: got %b want 0", pass_b); end
    endtask

    task automatic test_saturate();
        int cyc;
        cyc = 0;
        start_run(2, 16'd40);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++; if (err_c !== 4'd15) begin tests_failed++; $display("[TB] FAIL sat_mid: got %0d want 15", err_c); end
        wait_done(2, 200, cyc);
        tests_run++; if (cyc != 42) begin tests_failed++; $display("[TB] FAIL sat_latency: got %0d want 42", cyc); end
        tests_run++; if (err_c !== 4'd15) begin tests_failed++; $display("[TB] FAIL sat_final: got %0d want 15", err_c); end
        tests_run++; if (first_c !== 16'd0) begin tests_failed++; $display("[TB] FAIL sat_first: got %0d want 0", first_c); end
        tests_run++; if (pass_c !== 1'b0) begin tests_failed++; $display("[TB] FAIL sat_pass: got %b want 0", pass_c); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        stuck_a = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        num_a = 16'd0; num_b = 16'd0; num_c = 16'd0;
        test_reset();
        test_healthy();
        test_stuck_ff();
        test_num_zero();
        test_back_to_back();
        test_reset_midrun();
        test_latch_tie();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
